// File: rtl/lutnet_layer_pipe.sv
// Pipelined LogicNets layer: N runtime-programmable truth-table neurons behind valid/ready handshakes.
// Optional macro LUTNET_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module lutnet_layer_pipe #(
  parameter int N        = 8,
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  localparam int NW      = (N > 1) ? $clog2(N) : 1,
  localparam int DEPTH   = 2 ** FANIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*FANIN-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*OUT_BITS-1:0]   out_data,
  input  logic                    cfg_we,
  output logic                    cfg_ready,
  input  logic [NW-1:0]           cfg_neuron,
  input  logic [FANIN-1:0]        cfg_addr,
  input  logic [OUT_BITS-1:0]     cfg_data,
  output logic                    busy
);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t state_q, state_d;

  logic [OUT_BITS-1:0]   tbl [N][DEPTH];
  logic                  vld_p1;
  logic [N*OUT_BITS-1:0] data_p1;
  logic [N*FANIN-1:0]    lookup_src;
  logic [N*OUT_BITS-1:0] lookup_res;
  logic                  adv;
  logic                  accept;
  logic                  pipe_empty;
  logic                  drain_done;
  logic                  tbl_we;

  // The whole pipeline advances as one group whenever the output register can move.
  assign adv    = !vld_p1 || out_ready;
  assign accept = in_valid && in_ready;

`ifdef LUTNET_INPUT_REG_EN
  logic                  vld_p0;
  logic [N*FANIN-1:0]    data_p0;

  assign pipe_empty = !vld_p0 && !vld_p1;
  assign drain_done = !vld_p0 && (!vld_p1 || out_ready);
  assign lookup_src = data_p0;

  // Input register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && accept) begin
      data_p0 <= in_data;
    end
  end

  wire load_p1 = vld_p0;
`else
  assign pipe_empty = !vld_p1;
  assign drain_done = !vld_p1 || out_ready;
  assign lookup_src = in_data;

  wire load_p1 = accept;
`endif

  always_comb begin
    lookup_res = '0;
    for (int i = 0; i < N; i++) begin
      lookup_res[i*OUT_BITS +: OUT_BITS] = tbl[i][lookup_src[i*FANIN +: FANIN]];
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (adv) begin
      vld_p1 <= load_p1;
      if (load_p1) begin
        data_p1 <= lookup_res;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (cfg_we) state_d = pipe_empty ? LOAD : DRAIN;
      DRAIN:   if (drain_done) state_d = LOAD;
      LOAD:    if (!cfg_we) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign in_ready  = (state_q == RUN) && !cfg_we && adv;
  assign cfg_ready = (state_q == LOAD);
  assign busy      = (state_q != RUN) || !pipe_empty;

  // Out-of-range neuron indices complete the handshake but leave every table untouched.
  assign tbl_we = cfg_ready && cfg_we && (int'(cfg_neuron) < N);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          tbl[i][j] <= '0;
        end
      end
    end else if (tbl_we) begin
      tbl[cfg_neuron][cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_lutnet_layer_pipe.sv
// Directed self-checking bench for lutnet_layer_pipe (default N=8/FANIN=6/OUT_BITS=1 plus a small N=5 instance).
module tb_lutnet_layer_pipe;

`ifdef LUTNET_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  int checks = 0;
  int errs   = 0;

`define CHK(tag, o, e) begin checks++; assert ((o) === (e)) else begin errs++; $error("FAIL %s: observed=%0h expected=%0h", tag, (o), (e)); end end

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [47:0] in_data = '0;
  logic [7:0]  out_data;
  logic        cfg_we = 1'b0, cfg_ready, busy;
  logic [2:0]  cfg_neuron = '0;
  logic [5:0]  cfg_addr = '0;
  logic [0:0]  cfg_data = '0;

  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1;
  logic [9:0]  in_data2 = '0, out_data2;
  logic        cfg_we2 = 1'b0, cfg_ready2, busy2;
  logic [2:0]  cfg_neuron2 = '0;
  logic [1:0]  cfg_addr2 = '0, cfg_data2 = '0;

  always #5 clk = ~clk;

  lutnet_layer_pipe #(.N(8), .FANIN(6), .OUT_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .busy(busy)
  );

  lutnet_layer_pipe #(.N(5), .FANIN(2), .OUT_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .cfg_we(cfg_we2), .cfg_ready(cfg_ready2), .cfg_neuron(cfg_neuron2), .cfg_addr(cfg_addr2),
    .cfg_data(cfg_data2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fdat(input int mode, input int a);
    if (mode == 0) return a[0];
    return a[2] ^ a[5];
  endfunction

  function automatic logic [47:0] vec(input int k);
    logic [47:0] v;
    v = '0;
    v[5:0] = k[5:0];
    if (k % 3 == 0) v[23:18] = 6'd5;
    return v;
  endfunction

  function automatic logic [7:0] vexp(input int k);
    logic [7:0] e;
    e = '0;
    e[0] = k[0];
    e[3] = (k % 3 == 0);
    return e;
  endfunction

  task automatic send(input logic [47:0] d, input logic [7:0] e, input string tag);
    bit got = 1'b0;
    in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #2; got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    `CHK("send_accept", got, 1'b1)
    repeat (LAT - 1) tick();
    #2;
    `CHK("send_valid", out_valid, 1'b1)
    `CHK(tag, out_data, e)
    tick();
  endtask

  task automatic cfg_write(input int nr, input int a, input logic d);
    bit got = 1'b0;
    cfg_we = 1'b1; cfg_neuron = nr[2:0]; cfg_addr = a[5:0]; cfg_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      #2; got = cfg_ready;
      tick();
    end
    `CHK("cfg_handshake", got, 1'b1)
    cfg_we = 1'b0;
    tick();
  endtask

  task automatic cfg_burst(input int nr, input int mode);
    bit got = 1'b0;
    cfg_we = 1'b1; cfg_neuron = nr[2:0]; cfg_addr = '0; cfg_data = fdat(mode, 0);
    for (int i = 0; i < 20 && !got; i++) begin
      #2; got = cfg_ready;
      if (!got) tick();
    end
    `CHK("burst_enter_load", got, 1'b1)
    for (int a = 0; a < 64; a++) begin
      cfg_addr = a[5:0]; cfg_data = fdat(mode, a);
      #1;
      `CHK("burst_cfg_ready", cfg_ready, 1'b1)
      tick();
    end
    cfg_we = 1'b0;
    #2;
    `CHK("burst_still_load", cfg_ready, 1'b1)
    `CHK("burst_load_in_ready", in_ready, 1'b0)
    tick();
    #2;
    `CHK("burst_run_in_ready", in_ready, 1'b1)
    `CHK("burst_run_busy", busy, 1'b0)
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d3;
    logic [7:0]  cap[$];
    logic [7:0]  held;
    logic [1:0]  v2;
    logic [5:0]  a6;
    logic [9:0]  exp2;
    bit          got, stalled;
    int          k, ncap;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    #2;
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_out_data", out_data, 8'h00)
    `CHK("rst_in_ready", in_ready, 1'b1)
    `CHK("rst_cfg_ready", cfg_ready, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_out_valid2", out_valid2, 1'b0)
    tick();

    // Single entry: neuron 3, addr 5 = 1
    cfg_write(3, 5, 1'b1);
    d3 = '0; d3[23:18] = 6'd5;
    send(d3, 8'h08, "single_hit");
    d3[23:18] = 6'd6;
    send(d3, 8'h00, "single_miss");
    send({8{6'd5}}, 8'h08, "single_all_slices");
    d3 = '0; d3[23:18] = 6'd5;

    // Small instance: out-of-range neuron writes are accepted and ignored
    cfg_we2 = 1'b1; cfg_neuron2 = 3'd1; cfg_addr2 = 2'd2; cfg_data2 = 2'd3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #2; got = cfg_ready2;
      tick();
    end
    `CHK("n2_handshake", got, 1'b1)
    cfg_neuron2 = 3'd5; cfg_addr2 = 2'd1; cfg_data2 = 2'd1;
    #2;
    `CHK("n2_oob5_ready", cfg_ready2, 1'b1)
    tick();
    cfg_neuron2 = 3'd7; cfg_addr2 = 2'd3; cfg_data2 = 2'd2;
    #2;
    `CHK("n2_oob7_ready", cfg_ready2, 1'b1)
    tick();
    cfg_we2 = 1'b0;
    tick();
    for (int v = 0; v < 4; v++) begin
      v2 = v[1:0];
      in_data2 = {5{v2}}; in_valid2 = 1'b1;
      #2;
      checks++;
      if (in_ready2 !== 1'b1) begin
        errs++; $error("FAIL n2_in_ready: observed=%0h expected=1", in_ready2);
      end
      tick();
      in_valid2 = 1'b0;
      repeat (LAT - 1) tick();
      #2;
      checks++;
      if (out_valid2 !== 1'b1) begin
        errs++; $error("FAIL n2_out_valid: observed=%0h expected=1", out_valid2);
      end
      exp2 = (v == 2) ? 10'h00C : 10'h000;
      checks++;
      if (out_data2 !== exp2) begin
        errs++; $error("FAIL n2_sweep: observed=%0h expected=%0h", out_data2, exp2);
      end
      tick();
    end

    // Streaming with out_ready toggling 1,0,1,0
    cfg_burst(0, 0);
    k = 0; ncap = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 100 && ncap < 10; c++) begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errs++; $error("FAIL stall_valid: observed=%0h expected=1", out_valid);
        end
        checks++;
        if (out_data !== held) begin
          errs++; $error("FAIL stall_data: observed=%0h expected=%0h", out_data, held);
        end
      end
      out_ready = (c % 2 == 0);
      in_valid = (k < 10);
      in_data = vec(k);
      #2;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        cap.push_back(out_data);
        ncap++;
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    `CHK("stream_count", ncap, 10)
    for (int j = 0; j < 10 && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== vexp(j)) begin
        errs++; $error("FAIL stream_data: observed=%0h expected=%0h", cap[j], vexp(j));
      end
    end
    repeat (3) begin
      #2;
      `CHK("stream_no_dup", out_valid, 1'b0)
      tick();
    end

    // Config request during traffic
    out_ready = 1'b0;
    in_data = d3; in_valid = 1'b1; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #2; got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    `CHK("cfgt_accept", got, 1'b1)
    repeat (LAT - 1) tick();
    #2;
    `CHK("cfgt_inflight", out_valid, 1'b1)
    cfg_we = 1'b1; cfg_neuron = 3'd3; cfg_addr = 6'd5; cfg_data = 1'b0;
    #1;
    `CHK("cfgt_in_ready_blocked", in_ready, 1'b0)
    `CHK("cfgt_cfg_ready_run", cfg_ready, 1'b0)
    tick();
    #2;
    `CHK("cfgt_cfg_ready_drain", cfg_ready, 1'b0)
    `CHK("cfgt_busy_drain", busy, 1'b1)
    `CHK("cfgt_old_table", out_data, 8'h08)
    out_ready = 1'b1;
    #1;
    `CHK("cfgt_cfg_ready_pre_hs", cfg_ready, 1'b0)
    tick();
    #1;
    `CHK("cfgt_cfg_ready_load", cfg_ready, 1'b1)
    `CHK("cfgt_drained", out_valid, 1'b0)
    tick();
    cfg_we = 1'b0;
    tick();
    send(d3, 8'h00, "cfgt_new_table");

    // Burst load of neuron 7 and read-back of all 64 entries
    cfg_burst(7, 1);
    for (int a = 0; a < 64; a++) begin
      d3 = '0; d3[47:42] = a[5:0];
      send(d3, {fdat(1, a), 7'b0}, "readback_n7");
    end

    // Reset in the middle of a LOAD burst
    cfg_we = 1'b1; cfg_neuron = 3'd2; cfg_addr = '0; cfg_data = 1'b1; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #2; got = cfg_ready;
      if (!got) tick();
    end
    `CHK("rload_enter", got, 1'b1)
    for (int a = 0; a < 5; a++) begin
      cfg_addr = a[5:0];
      tick();
    end
    rst = 1'b1; cfg_we = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    `CHK("rload_out_valid", out_valid, 1'b0)
    `CHK("rload_busy", busy, 1'b0)
    `CHK("rload_cfg_ready", cfg_ready, 1'b0)
    `CHK("rload_in_ready", in_ready, 1'b1)
    tick();
    for (int a = 0; a < 7; a++) begin
      a6 = (a == 6) ? 6'd63 : a[5:0];
      send({8{a6}}, 8'h00, "rload_cleared");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
